// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants for the kij instruction sequencer:
//                instruction-bus bit positions, the idle instruction word
//                and the sequencer state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  // Instruction bus layout, bit 34 down to bit 0
  localparam int INST_W        = 35;
  localparam int INST_AW       = 11;  // width of each memory address field
  localparam int INST_MODE     = 34;
  localparam int INST_ACC      = 33;
  localparam int INST_CEN_PMEM = 32;
  localparam int INST_WEN_PMEM = 31;
  localparam int INST_A_PMEM   = 20;  // lsb of A_pmem[10:0]
  localparam int INST_CEN_XMEM = 19;
  localparam int INST_WEN_XMEM = 18;
  localparam int INST_A_XMEM   = 7;   // lsb of A_xmem[10:0]
  localparam int INST_OFIFO_RD = 6;
  localparam int INST_IFIFO_WR = 5;
  localparam int INST_IFIFO_RD = 4;
  localparam int INST_L0_RD    = 3;
  localparam int INST_L0_WR    = 2;
  localparam int INST_EXECUTE  = 1;
  localparam int INST_LOAD     = 0;

  // Both memories deselected with write disabled, every other field zero
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1_800C_0000;

  // Sequencer states
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_L0    = 4'd1;
  localparam logic [3:0] S_G1      = 4'd2;
  localparam logic [3:0] S_L_PRE   = 4'd3;
  localparam logic [3:0] S_W_LOAD  = 4'd4;
  localparam logic [3:0] S_G2      = 4'd5;
  localparam logic [3:0] S_X_L0    = 4'd6;
  localparam logic [3:0] S_G3      = 4'd7;
  localparam logic [3:0] S_E_PRE   = 4'd8;
  localparam logic [3:0] S_EXEC    = 4'd9;
  localparam logic [3:0] S_FLUSH   = 4'd10;
  localparam logic [3:0] S_WAIT_OV = 4'd11;
  localparam logic [3:0] S_OF_RD   = 4'd12;
  localparam logic [3:0] S_PM_WR   = 4'd13;
  localparam logic [3:0] S_NEXT    = 4'd14;
  localparam logic [3:0] S_DONE    = 4'd15;

endpackage
`default_nettype wire

// File: rtl/seq_counter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_counter
//  Description : Loadable down-counter that times each multi-cycle sequencer
//                state. Loaded with (length-1) on state entry, it counts
//                down and holds at zero. zero marks the final cycle of the
//                state, last marks the cycle before it.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] r_count;

  // Load on state entry, otherwise count down and saturate at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign zero = (r_count == '0);
  assign last = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/kij_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : kij_sequencer
//  Description : Generates the core's 35-bit instruction stream for all kij
//                weight passes: kernel xmem->L0->PE load, activation
//                xmem->L0, execute (+flush in OS mode), OFIFO->pmem drain.
//                Every output is registered; the instruction register is
//                loaded with the decode of the state being entered, so the
//                bus always reflects the current state of the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module kij_sequencer
  import core_pkg::*;
#(
  parameter int          ROW       = 8,
  parameter int          COL       = 8,
  parameter int          LEN_NIJ   = 36,
  parameter int          LEN_KIJ   = 9,
  parameter int          ADDR_W    = 11,
  parameter int unsigned W_BASE    = 32'h400,
  parameter int          FLUSH_LEN = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_os,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic [3:0]        kij_idx
);

  localparam int         EXEC_LEN = LEN_NIJ + ROW + COL;
  // Sum of the longest lengths is a safe upper bound for the counter range
  localparam int         CNT_W    = $clog2(EXEC_LEN + LEN_NIJ + COL + FLUSH_LEN + 1);
  localparam logic [3:0] KIJ_LAST = 4'(LEN_KIJ - 1);

  // Parameter sanity: address spaces must hold every pass without wrap
  generate
    if (LEN_KIJ * LEN_NIJ > (1 << ADDR_W)) begin : g_chk_pmem_span
      $error("kij_sequencer: LEN_KIJ*LEN_NIJ exceeds the pmem address space");
    end
    if (W_BASE + LEN_KIJ * COL > (1 << ADDR_W)) begin : g_chk_xmem_span
      $error("kij_sequencer: weight region exceeds the xmem address space");
    end
    if (LEN_KIJ > 16 || LEN_KIJ < 1) begin : g_chk_kij_range
      $error("kij_sequencer: LEN_KIJ must fit the 4-bit kij_idx");
    end
    if (ADDR_W > INST_AW) begin : g_chk_addr_w
      $error("kij_sequencer: ADDR_W wider than the instruction address fields");
    end
  endgenerate

  // Cycles spent in each state, minus one (single-cycle states load zero)
  function automatic logic [CNT_W-1:0] state_len_m1(input logic [3:0] s);
    int n;
    case (s)
      S_W_L0, S_W_LOAD: n = COL;
      S_X_L0, S_PM_WR:  n = LEN_NIJ;
      S_EXEC:           n = EXEC_LEN;
      S_FLUSH:          n = FLUSH_LEN;
      default:          n = 1;
    endcase
    return CNT_W'(n - 1);
  endfunction

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;
  logic              w_enter;
  logic [CNT_W-1:0]  w_cnt_load_val;
  logic              w_cnt_zero;
  logic              w_cnt_last;

  logic              r_mode;
  logic [3:0]        r_kij;
  logic [ADDR_W-1:0] r_xaddr;
  logic [ADDR_W-1:0] w_xaddr_nxt;
  logic [ADDR_W-1:0] r_wbase;   // first weight address of the current kij
  logic [ADDR_W-1:0] r_pcount;  // next pmem address to be written
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic              w_ofifo_rd_nxt;
  logic [INST_W-1:0] r_inst;
  logic [INST_W-1:0] w_inst_nxt;
  logic              r_busy;
  logic              r_done;

  assign w_enter        = (w_state_nxt != r_state);
  assign w_cnt_load_val = state_len_m1(w_state_nxt);

  seq_counter #(
    .WIDTH (CNT_W)
  ) u_seq_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_enter),
    .load_val (w_cnt_load_val),
    .zero     (w_cnt_zero),
    .last     (w_cnt_last)
  );

  // Next-state decision: timed states leave on the counter's final cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start)       w_state_nxt = S_W_L0;
      S_W_L0:    if (w_cnt_zero)  w_state_nxt = S_G1;
      S_G1:                       w_state_nxt = S_L_PRE;
      S_L_PRE:                    w_state_nxt = S_W_LOAD;
      S_W_LOAD:  if (w_cnt_zero)  w_state_nxt = S_G2;
      S_G2:                       w_state_nxt = S_X_L0;
      S_X_L0:    if (w_cnt_zero)  w_state_nxt = S_G3;
      S_G3:                       w_state_nxt = S_E_PRE;
      S_E_PRE:                    w_state_nxt = S_EXEC;
      S_EXEC:    if (w_cnt_zero)  w_state_nxt = r_mode ? S_FLUSH : S_WAIT_OV;
      S_FLUSH:   if (w_cnt_zero)  w_state_nxt = S_WAIT_OV;
      S_WAIT_OV: if (ofifo_valid) w_state_nxt = S_OF_RD;
      S_OF_RD:                    w_state_nxt = S_PM_WR;
      S_PM_WR:   if (w_cnt_zero)  w_state_nxt = S_NEXT;
      S_NEXT:    w_state_nxt = (r_kij == KIJ_LAST) ? S_DONE : S_W_L0;
      S_DONE:                     w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Address and instruction word for the cycle about to begin
  always_comb begin
    w_xaddr_nxt = '0;
    if (w_state_nxt == S_W_L0) begin
      w_xaddr_nxt = w_enter ? r_wbase : r_xaddr + ADDR_W'(1);
    end else if (w_state_nxt == S_X_L0) begin
      w_xaddr_nxt = w_enter ? '0 : r_xaddr + ADDR_W'(1);
    end

    w_paddr_nxt = (w_state_nxt == S_PM_WR) ? r_pcount : '0;

    // The OFIFO read stream runs one ahead of the writes, so it stops
    // on the final pmem write of the pass.
    w_ofifo_rd_nxt = (w_state_nxt == S_OF_RD) ||
                     ((w_state_nxt == S_PM_WR) &&
                      (w_enter ? (LEN_NIJ > 1) : !w_cnt_last));

    w_inst_nxt = INST_IDLE;
    case (w_state_nxt)
      S_W_L0: begin
        w_inst_nxt[INST_CEN_XMEM]            = 1'b0;
        w_inst_nxt[INST_L0_WR]               = 1'b1;
        w_inst_nxt[INST_A_XMEM +: INST_AW]   = INST_AW'(w_xaddr_nxt);
      end
      S_G1, S_G2, S_G3: begin
        w_inst_nxt[INST_MODE]                = r_mode;
      end
      S_L_PRE, S_E_PRE: begin
        w_inst_nxt[INST_MODE]                = r_mode;
        w_inst_nxt[INST_L0_RD]               = 1'b1;
      end
      S_W_LOAD: begin
        w_inst_nxt[INST_MODE]                = r_mode;
        w_inst_nxt[INST_L0_RD]               = 1'b1;
        w_inst_nxt[INST_LOAD]                = 1'b1;
      end
      S_X_L0: begin
        w_inst_nxt[INST_MODE]                = r_mode;
        w_inst_nxt[INST_CEN_XMEM]            = 1'b0;
        w_inst_nxt[INST_L0_WR]               = 1'b1;
        w_inst_nxt[INST_A_XMEM +: INST_AW]   = INST_AW'(w_xaddr_nxt);
      end
      S_EXEC: begin
        w_inst_nxt[INST_MODE]                = r_mode;
        w_inst_nxt[INST_L0_RD]               = 1'b1;
        w_inst_nxt[INST_EXECUTE]             = 1'b1;
      end
      S_FLUSH: begin
        // Drain cycles: array keeps stepping with no new operands
        w_inst_nxt[INST_EXECUTE]             = 1'b1;
      end
      S_OF_RD: begin
        w_inst_nxt[INST_OFIFO_RD]            = 1'b1;
      end
      S_PM_WR: begin
        w_inst_nxt[INST_OFIFO_RD]            = w_ofifo_rd_nxt;
        w_inst_nxt[INST_CEN_PMEM]            = 1'b0;
        w_inst_nxt[INST_WEN_PMEM]            = 1'b0;
        w_inst_nxt[INST_A_PMEM +: INST_AW]   = INST_AW'(w_paddr_nxt);
      end
      default: ;
    endcase
  end

  // State, instruction and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_inst  <= INST_IDLE;
      r_xaddr <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_inst  <= w_inst_nxt;
      r_xaddr <= w_xaddr_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  // Run bookkeeping: latched mode, kij index and running address bases
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode   <= 1'b0;
      r_kij    <= '0;
      r_wbase  <= ADDR_W'(W_BASE);
      r_pcount <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mode <= mode_os;
      end

      if (w_state_nxt == S_IDLE) begin
        r_kij <= '0;
      end else if (r_state == S_NEXT && w_state_nxt == S_W_L0) begin
        r_kij <= r_kij + 4'd1;
      end

      // Next kij's weights follow directly after the current block
      if (r_state == S_IDLE) begin
        r_wbase <= ADDR_W'(W_BASE);
      end else if (r_state == S_W_L0 && w_state_nxt != S_W_L0) begin
        r_wbase <= r_xaddr + ADDR_W'(1);
      end

      if (r_state == S_IDLE) begin
        r_pcount <= '0;
      end else if (w_state_nxt == S_PM_WR) begin
        r_pcount <= r_pcount + ADDR_W'(1);
      end
    end
  end

  assign inst    = r_inst;
  assign busy    = r_busy;
  assign done    = r_done;
  assign kij_idx = r_kij;

endmodule
`default_nettype wire

// File: tb/tb_kij_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_kij_sequencer
//  Description : Directed self-checking bench for kij_sequencer. Inputs are
//                driven and outputs sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kij_sequencer;

  localparam int COL       = 8;
  localparam int LEN_NIJ   = 36;
  localparam int LEN_KIJ   = 9;
  localparam int W_BASE    = 'h400;
  localparam int FLUSH_LEN = 10;
  localparam int EXEC_LEN  = 52;   // LEN_NIJ + ROW + COL
  // One WS pass, state by state: W_L0 8 + G1 1 + L_PRE 1 + W_LOAD 8 + G2 1
  // + X_L0 36 + G3 1 + E_PRE 1 + EXEC 52 + WAIT_OV 1 + OF_RD 1 + PM_WR 36
  // + NEXT 1 = 148 cycles with ofifo_valid already high.
  localparam int PASS_WS   = 148;
  localparam logic [34:0] IDLE_INST = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mode_os;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij_idx;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  kij_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode_os     (mode_os),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .kij_idx     (kij_idx)
  );

  // Instruction field views
  logic        b_mode, b_acc, b_cen_p, b_wen_p, b_cen_x, b_wen_x;
  logic        b_ofifo_rd, b_ififo_wr, b_ififo_rd, b_l0_rd, b_l0_wr, b_execute, b_load;
  logic [10:0] b_a_pmem, b_a_xmem;
  assign b_mode     = inst[34];
  assign b_acc      = inst[33];
  assign b_cen_p    = inst[32];
  assign b_wen_p    = inst[31];
  assign b_a_pmem   = inst[30:20];
  assign b_cen_x    = inst[19];
  assign b_wen_x    = inst[18];
  assign b_a_xmem   = inst[17:7];
  assign b_ofifo_rd = inst[6];
  assign b_ififo_wr = inst[5];
  assign b_ififo_rd = inst[4];
  assign b_l0_rd    = inst[3];
  assign b_l0_wr    = inst[2];
  assign b_execute  = inst[1];
  assign b_load     = inst[0];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete run, monitored cycle by cycle against a reference model
  task automatic run_seq(input logic os, input bit stall, input bit extra_start, input string tag);
    int q[$];
    int e;
    int cyc        = 0;
    int tail       = -1;
    int busy_cyc   = 0;
    int done_cnt   = 0;
    int addr_err   = 0;
    int mode_err   = 0;
    int zero_err   = 0;
    int pm_err     = 0;
    int rd_err     = 0;
    int exec_cnt   = 0;
    int flush_cnt  = 0;
    int load_cnt   = 0;
    int exp_p      = 0;
    int pm_in_pass = 0;
    int stall_idle = 0;
    int stall_brk  = 0;
    bit seen_exec3 = 0;
    bit stall_done = 0;
    bit chk_resume = 0;
    logic resume_rd = 1'b0;
    int exp_busy;

    for (int k = 0; k < LEN_KIJ; k++) begin
      for (int i = 0; i < COL; i++)     q.push_back(W_BASE + k * COL + i);
      for (int i = 0; i < LEN_NIJ; i++) q.push_back(i | (1 << 16));
    end

    @(negedge clk);
    mode_os = os; ofifo_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode_os = ~os;   // must have been latched already

    while (cyc < 4000 && tail != 0) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (tail < 0) tail = 4;
      end
      if (b_acc || b_ififo_wr || b_ififo_rd) zero_err++;
      if (b_l0_wr) begin
        if (q.size() == 0) addr_err++;
        else begin
          e = q.pop_front();
          if (b_a_xmem != 11'(e) || b_cen_x != 1'b0 || b_wen_x != 1'b1) addr_err++;
          if (e[16] && b_mode != os) mode_err++;
        end
      end
      if (b_load) begin
        load_cnt++;
        if (b_mode != os) mode_err++;
      end
      if (b_execute && b_l0_rd) begin
        exec_cnt++;
        if (b_mode != os) mode_err++;
      end
      if (b_execute && !b_l0_rd) begin
        flush_cnt++;
        if (b_mode != 1'b0) mode_err++;
      end
      if (!b_wen_p) begin
        if (b_a_pmem != 11'(exp_p) || b_cen_p != 1'b0) pm_err++;
        pm_in_pass++;
        if (b_ofifo_rd != (pm_in_pass != LEN_NIJ)) rd_err++;
        if (pm_in_pass == LEN_NIJ) pm_in_pass = 0;
        exp_p++;
      end
      if (stall) begin
        if (chk_resume) begin
          resume_rd  = b_ofifo_rd;
          chk_resume = 0;
        end
        if (kij_idx == 4'd3 && !seen_exec3 && !stall_done) ofifo_valid = 1'b0;
        if (kij_idx == 4'd3 && b_execute) seen_exec3 = 1;
        else if (seen_exec3 && !stall_done) begin
          if (inst == IDLE_INST) begin
            stall_idle++;
            if (stall_idle == 21) begin
              ofifo_valid = 1'b1;
              stall_done  = 1;
              chk_resume  = 1;
            end
          end else stall_brk++;
        end
      end
      if (extra_start && cyc == 500) start = 1'b1;
      if (extra_start && cyc == 501) start = 1'b0;
      @(negedge clk);
      cyc++;
      if (tail > 0) tail--;
    end

    exp_busy = LEN_KIJ * (PASS_WS + (os ? FLUSH_LEN : 0)) + (stall ? 20 : 0);
    check({tag, ".busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    check({tag, ".done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ".xmem_addr_err"}, 64'(addr_err), 64'd0);
    check({tag, ".l0_wr_left"}, 64'(q.size()), 64'd0);
    check({tag, ".mode_err"}, 64'(mode_err), 64'd0);
    check({tag, ".zero_fields"}, 64'(zero_err), 64'd0);
    check({tag, ".load_cycles"}, 64'(load_cnt), 64'(LEN_KIJ * COL));
    check({tag, ".exec_cycles"}, 64'(exec_cnt), 64'(LEN_KIJ * EXEC_LEN));
    check({tag, ".flush_cycles"}, 64'(flush_cnt), 64'(os ? LEN_KIJ * FLUSH_LEN : 0));
    check({tag, ".pmem_writes"}, 64'(exp_p), 64'(LEN_KIJ * LEN_NIJ));
    check({tag, ".pmem_addr_err"}, 64'(pm_err), 64'd0);
    check({tag, ".ofifo_rd_err"}, 64'(rd_err), 64'd0);
    check({tag, ".idle_after"}, 64'(inst), 64'(IDLE_INST));
    if (stall) begin
      check({tag, ".stall_idle_len"}, 64'(stall_idle), 64'd21);
      check({tag, ".stall_idle_break"}, 64'(stall_brk), 64'd0);
      check({tag, ".resume_ofifo_rd"}, 64'(resume_rd), 64'd1);
    end
  endtask

  // Abort a run mid-EXEC of kij 4 with reset
  task automatic reset_mid_exec();
    int cyc = 0;
    int ex  = 0;
    @(negedge clk);
    mode_os = 1'b0; ofifo_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < 3000 && ex < 10) begin
      if (kij_idx == 4'd4 && b_execute) ex++;
      if (ex < 10) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("rst_mid.reached_exec", 64'(ex), 64'd10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid.inst", 64'(inst), 64'(IDLE_INST));
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.kij_idx", 64'(kij_idx), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    @(negedge clk);
    check("rst_mid.hold_inst", 64'(inst), 64'(IDLE_INST));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode_os = 1'b0; ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.inst", 64'(inst), 64'(IDLE_INST));
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.kij_idx", 64'(kij_idx), 64'd0);

    // start coincident with reset: reset wins, nothing launches
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_start.busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_start.busy_hold", 64'(busy), 64'd0);
    check("rst_start.inst", 64'(inst), 64'(IDLE_INST));

    run_seq(1'b0, 1'b0, 1'b0, "ws");
    run_seq(1'b1, 1'b0, 1'b1, "os_restart_ignored");
    run_seq(1'b0, 1'b1, 1'b0, "ws_stall");
    reset_mid_exec();
    run_seq(1'b0, 1'b0, 1'b0, "ws_after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
